// File: rtl/mem_pkg.sv
// Shared types and constants for the data-memory side of the pipeline.
package mem_pkg;

  localparam int SB_DEPTH         = 4;
  localparam int SB_ADDR_W        = 32;
  localparam int SB_DATA_W        = 64;
  localparam int WORD_OFFSET_BITS = 3;

  // One buffered store: full byte address plus the word being written.
  typedef struct packed {
    logic [SB_ADDR_W-1:0] addr;
    logic [SB_DATA_W-1:0] data;
  } sb_entry_t;

endpackage

// File: rtl/sb_match.sv
// Youngest-match finder: scans the live window of the store buffer from
// oldest (head) to youngest (tail-1) so that a later hit overrides an earlier one.
// The top feeds in the word part of every entry's address.
module sb_match
  import mem_pkg::*;
#(
  parameter int DEPTH  = SB_DEPTH,
  parameter int WORD_W = SB_ADDR_W - WORD_OFFSET_BITS,
  parameter int PTR_W  = $clog2(DEPTH) + 1,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic [WORD_W-1:0] i_words [DEPTH],
  input  logic [PTR_W-1:0]  i_head,
  input  logic [PTR_W-1:0]  i_tail,
  input  logic [WORD_W-1:0] i_word,
  output logic              o_hit,
  output logic [IDX_W-1:0]  o_idx
);

  logic [PTR_W-1:0] w_count;
  logic [IDX_W-1:0] w_slot;

  assign w_count = i_tail - i_head;

  // Walk oldest to youngest; the last live match seen is the youngest one.
  always_comb begin
    o_hit  = 1'b0;
    o_idx  = '0;
    w_slot = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_slot = i_head[IDX_W-1:0] + IDX_W'(k);
      if ((PTR_W'(k) < w_count) && (i_words[w_slot] == i_word)) begin
        o_hit = 1'b1;
        o_idx = w_slot;
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// In-order store buffer between the MEM stage and the data memory write port.
// Stores are queued in one cycle, drained one per cycle when no load owns the
// port, and loads are forwarded from the youngest matching buffered store.
module store_buffer
  import mem_pkg::*;
#(
  parameter int DEPTH  = SB_DEPTH,
  parameter int ADDR_W = SB_ADDR_W,
  parameter int DATA_W = SB_DATA_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   st_valid,
  input  logic [ADDR_W-1:0]      st_addr,
  input  logic [DATA_W-1:0]      st_data,
  output logic                   st_ready,
  input  logic                   ld_valid,
  input  logic [ADDR_W-1:0]      ld_addr,
  output logic                   ld_stall,
  output logic [DATA_W-1:0]      ld_data,
  input  logic [DATA_W-1:0]      mem_rd_data,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic [DATA_W-1:0]      mem_wr_data,
  output logic                   mem_wr_en,
  output logic                   mem_rd_en,
  input  logic                   drain,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W  = $clog2(DEPTH) + 1;
  localparam int IDX_W  = $clog2(DEPTH);
  localparam int WORD_W = ADDR_W - WORD_OFFSET_BITS;

  sb_entry_t        r_entries [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;

  logic [WORD_W-1:0] w_words [DEPTH];
  sb_entry_t         w_head_entry;
  logic [PTR_W-1:0]  w_count;
  logic              w_empty;
  logic              w_full;
  logic              w_load_port;
  logic              w_drain_go;
  logic              w_enq;
  logic              w_hit;
  logic [IDX_W-1:0]  w_hit_idx;

  assign w_count      = r_tail - r_head;
  assign w_empty      = (r_head == r_tail);
  assign w_full       = (r_head[IDX_W-1:0] == r_tail[IDX_W-1:0]) &&
                        (r_head[PTR_W-1] != r_tail[PTR_W-1]);
  assign w_head_entry = r_entries[r_head[IDX_W-1:0]];

  // A load owns the port unless the buffer is full; a full buffer must drain
  // first so the stalled upstream store can eventually get in.
  assign w_load_port = ld_valid && !w_full;
  assign w_drain_go  = !w_empty && (!ld_valid || w_full);
  assign w_enq       = st_valid && st_ready;

  // Word addresses of every slot, for the forwarding comparator.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_words[i] = r_entries[i].addr[ADDR_W-1:WORD_OFFSET_BITS];
    end
  end

  sb_match #(
    .DEPTH  (DEPTH),
    .WORD_W (WORD_W),
    .PTR_W  (PTR_W),
    .IDX_W  (IDX_W)
  ) u_match (
    .i_words (w_words),
    .i_head  (r_head),
    .i_tail  (r_tail),
    .i_word  (ld_addr[ADDR_W-1:WORD_OFFSET_BITS]),
    .o_hit   (w_hit),
    .o_idx   (w_hit_idx)
  );

  // Port arbitration and visible status; everything is forced quiet while in reset.
  always_comb begin
    st_ready    = 1'b0;
    ld_stall    = 1'b0;
    mem_wr_en   = 1'b0;
    mem_rd_en   = 1'b0;
    ld_data     = '0;
    mem_addr    = '0;
    mem_wr_data = '0;
    empty       = 1'b1;
    count       = '0;
    if (rst) begin
      st_ready = !w_full && !drain;
      empty    = w_empty;
      count    = w_count;
      ld_stall = ld_valid && w_full;
      ld_data  = w_hit ? r_entries[w_hit_idx].data : mem_rd_data;
      if (w_load_port) begin
        mem_rd_en = 1'b1;
        mem_addr  = ld_addr;
      end else if (w_drain_go) begin
        mem_wr_en   = 1'b1;
        mem_addr    = w_head_entry.addr;
        mem_wr_data = w_head_entry.data;
      end
    end
  end

  // Head/tail pointers; reset discards everything, including a drain in flight.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_head <= '0;
      r_tail <= '0;
    end else begin
      if (w_enq) begin
        r_tail <= r_tail + 1'b1;
      end
      if (w_drain_go) begin
        r_head <= r_head + 1'b1;
      end
    end
  end

  // Entry storage needs no reset: only slots between head and tail are ever read as live.
  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_entries[r_tail[IDX_W-1:0]] <= '{addr: st_addr, data: st_data};
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Directed self-checking bench for store_buffer with a small data memory model.
module tb_store_buffer;

  logic        clk;
  logic        rst;
  logic        st_valid;
  logic [31:0] st_addr;
  logic [63:0] st_data;
  logic        st_ready;
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic        ld_stall;
  logic [63:0] ld_data;
  logic [63:0] mem_rd_data;
  logic [31:0] mem_addr;
  logic [63:0] mem_wr_data;
  logic        mem_wr_en;
  logic        mem_rd_en;
  logic        drain;
  logic        empty;
  logic [2:0]  count;

  logic [63:0] dmem [256];
  logic [95:0] wrLog [$];
  int          nCompared;
  int          nMismatched;

  store_buffer dut (
    .clk         (clk),
    .rst         (rst),
    .st_valid    (st_valid),
    .st_addr     (st_addr),
    .st_data     (st_data),
    .st_ready    (st_ready),
    .ld_valid    (ld_valid),
    .ld_addr     (ld_addr),
    .ld_stall    (ld_stall),
    .ld_data     (ld_data),
    .mem_rd_data (mem_rd_data),
    .mem_addr    (mem_addr),
    .mem_wr_data (mem_wr_data),
    .mem_wr_en   (mem_wr_en),
    .mem_rd_en   (mem_rd_en),
    .drain       (drain),
    .empty       (empty),
    .count       (count)
  );

  // Free-running clock, 10 time units per cycle.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational-read data memory.
  assign mem_rd_data = dmem[mem_addr[10:3]];

  // Memory write port plus an ordered log of every write seen.
  always @(posedge clk) begin
    if (mem_wr_en) begin
      dmem[mem_addr[10:3]] <= mem_wr_data;
      wrLog.push_back({mem_addr, mem_wr_data});
    end
  end

  // Flag cycles where the MEM stage presents a store and a load together.
  always @(posedge clk) begin
    if (rst && st_valid && ld_valid) begin
      $display("[TB] note: st_valid and ld_valid overlap at time %0t", $time);
    end
  end

  task automatic setIdle();
    st_valid = 1'b0;
    ld_valid = 1'b0;
    st_addr  = '0;
    st_data  = '0;
    ld_addr  = '0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 8; i++) begin
      setIdle();
      case ($urandom_range(0, 2))
        0: begin
          st_valid = 1'b1;
          st_addr  = 32'h400 | (32'($urandom_range(0, 63)) << 3);
          st_data  = {$urandom, $urandom};
        end
        1: begin
          ld_valid = 1'b1;
          ld_addr  = 32'h400 | (32'($urandom_range(0, 63)) << 3);
        end
        default: ;
      endcase
      @(negedge clk);
    end
    setIdle();
    st_valid = 1'b1;
    st_addr  = 32'h600;
    st_data  = 64'h77;
    rst      = 1'b0;
    #1;
    nCompared++; if (st_ready !== 1'b0) begin nMismatched++; $display("[TB] FAIL rst1_st_ready: got %b want 0", st_ready); end
    nCompared++; if (mem_wr_en !== 1'b0) begin nMismatched++; $display("[TB] FAIL rst1_wr_en: got %b want 0", mem_wr_en); end
    nCompared++; if (empty !== 1'b1) begin nMismatched++; $display("[TB] FAIL rst1_empty: got %b want 1", empty); end
    @(negedge clk);
    setIdle();
    ld_valid = 1'b1;
    ld_addr  = 32'h408;
    #1;
    nCompared++; if (empty !== 1'b1) begin nMismatched++; $display("[TB] FAIL rst2_empty: got %b want 1", empty); end
    nCompared++; if (count !== 3'd0) begin nMismatched++; $display("[TB] FAIL rst2_count: got %0d want 0", count); end
    nCompared++; if (mem_wr_en !== 1'b0) begin nMismatched++; $display("[TB] FAIL rst2_wr_en: got %b want 0", mem_wr_en); end
    nCompared++; if (st_ready !== 1'b0) begin nMismatched++; $display("[TB] FAIL rst2_st_ready: got %b want 0", st_ready); end
    nCompared++; if (mem_rd_en !== 1'b0) begin nMismatched++; $display("[TB] FAIL rst2_rd_en: got %b want 0", mem_rd_en); end
    nCompared++; if (ld_stall !== 1'b0) begin nMismatched++; $display("[TB] FAIL rst2_ld_stall: got %b want 0", ld_stall); end
    nCompared++; if (ld_data !== 64'd0) begin nMismatched++; $display("[TB] FAIL rst2_ld_data: got %h want 0", ld_data); end
    nCompared++; if (mem_addr !== 32'd0) begin nMismatched++; $display("[TB] FAIL rst2_mem_addr: got %h want 0", mem_addr); end
    @(negedge clk);
    setIdle();
    rst = 1'b1;
    #1;
    nCompared++; if (st_ready !== 1'b1) begin nMismatched++; $display("[TB] FAIL post_rst_st_ready: got %b want 1", st_ready); end
    nCompared++; if (empty !== 1'b1) begin nMismatched++; $display("[TB] FAIL post_rst_empty: got %b want 1", empty); end
    nCompared++; if (count !== 3'd0) begin nMismatched++; $display("[TB] FAIL post_rst_count: got %0d want 0", count); end
    nCompared++; if (mem_wr_en !== 1'b0) begin nMismatched++; $display("[TB] FAIL post_rst_wr_en: got %b want 0", mem_wr_en); end
    @(negedge clk);
  endtask

  task automatic test_basic_drain();
    setIdle();
    st_valid = 1'b1;
    st_addr  = 32'h10;
    st_data  = 64'd5;
    #1;
    nCompared++; if (st_ready !== 1'b1) begin nMismatched++; $display("[TB] FAIL drain_st_ready: got %b want 1", st_ready); end
    nCompared++; if (mem_wr_en !== 1'b0) begin nMismatched++; $display("[TB] FAIL drain_latency: got wr_en %b want 0", mem_wr_en); end
    @(negedge clk);
    setIdle();
    #1;
    nCompared++; if (count !== 3'd1) begin nMismatched++; $display("[TB] FAIL drain_count: got %0d want 1", count); end
    nCompared++; if (mem_wr_en !== 1'b1) begin nMismatched++; $display("[TB] FAIL drain_wr_en: got %b want 1", mem_wr_en); end
    nCompared++; if (mem_addr !== 32'h10) begin nMismatched++; $display("[TB] FAIL drain_addr: got %h want 10", mem_addr); end
    nCompared++; if (mem_wr_data !== 64'd5) begin nMismatched++; $display("[TB] FAIL drain_data: got %h want 5", mem_wr_data); end
    @(negedge clk);
    #1;
    nCompared++; if (empty !== 1'b1) begin nMismatched++; $display("[TB] FAIL drain_empty: got %b want 1", empty); end
    nCompared++; if (dmem[2] !== 64'd5) begin nMismatched++; $display("[TB] FAIL drain_mem: got %h want 5", dmem[2]); end
    @(negedge clk);
  endtask

  task automatic test_forward();
    setIdle();
    st_valid = 1'b1; st_addr = 32'h20; st_data = 64'd1;
    ld_valid = 1'b1; ld_addr = 32'h20;
    #1;
    nCompared++; if (ld_data !== 64'hDEAD_0004) begin nMismatched++; $display("[TB] FAIL fwd_same_cycle: got %h want dead0004", ld_data); end
    nCompared++; if (mem_rd_en !== 1'b1) begin nMismatched++; $display("[TB] FAIL fwd_rd_en1: got %b want 1", mem_rd_en); end
    @(negedge clk);
    st_valid = 1'b1; st_addr = 32'h20; st_data = 64'd2;
    ld_valid = 1'b1; ld_addr = 32'h20;
    #1;
    nCompared++; if (ld_data !== 64'd1) begin nMismatched++; $display("[TB] FAIL fwd_single: got %h want 1", ld_data); end
    @(negedge clk);
    setIdle();
    ld_valid = 1'b1; ld_addr = 32'h20;
    #1;
    nCompared++; if (ld_data !== 64'd2) begin nMismatched++; $display("[TB] FAIL fwd_youngest: got %h want 2", ld_data); end
    nCompared++; if (mem_rd_en !== 1'b1) begin nMismatched++; $display("[TB] FAIL fwd_rd_en: got %b want 1", mem_rd_en); end
    nCompared++; if (mem_wr_en !== 1'b0) begin nMismatched++; $display("[TB] FAIL fwd_no_drain: got %b want 0", mem_wr_en); end
    nCompared++; if (count !== 3'd2) begin nMismatched++; $display("[TB] FAIL fwd_count: got %0d want 2", count); end
    @(negedge clk);
    ld_addr = 32'h27;
    #1;
    nCompared++; if (ld_data !== 64'd2) begin nMismatched++; $display("[TB] FAIL fwd_offset: got %h want 2", ld_data); end
    @(negedge clk);
    ld_addr = 32'h28;
    #1;
    nCompared++; if (ld_data !== 64'hBEEF_0005) begin nMismatched++; $display("[TB] FAIL fwd_miss: got %h want beef0005", ld_data); end
    @(negedge clk);
    setIdle();
    #1;
    nCompared++; if (mem_wr_data !== 64'd1) begin nMismatched++; $display("[TB] FAIL fwd_drain_old: got %h want 1", mem_wr_data); end
    @(negedge clk);
    #1;
    nCompared++; if (mem_wr_data !== 64'd2) begin nMismatched++; $display("[TB] FAIL fwd_drain_new: got %h want 2", mem_wr_data); end
    @(negedge clk);
    #1;
    nCompared++; if (dmem[4] !== 64'd2) begin nMismatched++; $display("[TB] FAIL fwd_mem: got %h want 2", dmem[4]); end
    @(negedge clk);
  endtask

  task automatic test_full_stall();
    for (int i = 0; i < 4; i++) begin
      setIdle();
      st_valid = 1'b1; st_addr = 32'h30 + 32'(i * 8); st_data = 64'hA0 + 64'(i);
      ld_valid = 1'b1; ld_addr = 32'h200;
      #1;
      nCompared++; if (st_ready !== 1'b1) begin nMismatched++; $display("[TB] FAIL fill_st_ready%0d: got %b want 1", i, st_ready); end
      @(negedge clk);
    end
    st_valid = 1'b1; st_addr = 32'h50; st_data = 64'hFF;
    ld_valid = 1'b1; ld_addr = 32'h200;
    #1;
    nCompared++; if (count !== 3'd4) begin nMismatched++; $display("[TB] FAIL full_count: got %0d want 4", count); end
    nCompared++; if (st_ready !== 1'b0) begin nMismatched++; $display("[TB] FAIL full_st_ready: got %b want 0", st_ready); end
    nCompared++; if (ld_stall !== 1'b1) begin nMismatched++; $display("[TB] FAIL full_ld_stall: got %b want 1", ld_stall); end
    nCompared++; if (mem_rd_en !== 1'b0) begin nMismatched++; $display("[TB] FAIL full_rd_en: got %b want 0", mem_rd_en); end
    nCompared++; if (mem_wr_en !== 1'b1) begin nMismatched++; $display("[TB] FAIL full_wr_en: got %b want 1", mem_wr_en); end
    nCompared++; if (mem_addr !== 32'h30) begin nMismatched++; $display("[TB] FAIL full_addr: got %h want 30", mem_addr); end
    @(negedge clk);
    setIdle();
    drain = 1'b1;
    #1;
    nCompared++; if (count !== 3'd3) begin nMismatched++; $display("[TB] FAIL stall_count: got %0d want 3", count); end
    nCompared++; if (st_ready !== 1'b0) begin nMismatched++; $display("[TB] FAIL fence_st_ready: got %b want 0", st_ready); end
    nCompared++; if (mem_addr !== 32'h38) begin nMismatched++; $display("[TB] FAIL fence_drain_addr: got %h want 38", mem_addr); end
    repeat (3) @(negedge clk);
    #1;
    nCompared++; if (empty !== 1'b1) begin nMismatched++; $display("[TB] FAIL fence_empty: got %b want 1", empty); end
    nCompared++; if (st_ready !== 1'b0) begin nMismatched++; $display("[TB] FAIL fence_hold: got %b want 0", st_ready); end
    drain = 1'b0;
    #1;
    nCompared++; if (st_ready !== 1'b1) begin nMismatched++; $display("[TB] FAIL fence_release: got %b want 1", st_ready); end
    nCompared++; if (dmem[6] !== 64'hA0) begin nMismatched++; $display("[TB] FAIL full_mem0: got %h want a0", dmem[6]); end
    nCompared++; if (dmem[9] !== 64'hA3) begin nMismatched++; $display("[TB] FAIL full_mem3: got %h want a3", dmem[9]); end
    nCompared++; if (dmem[10] !== 64'd0) begin nMismatched++; $display("[TB] FAIL full_rejected: got %h want 0", dmem[10]); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int          logStart;
    int          waited;
    logic [95:0] expWr [10];
    logic [63:0] refMem [4];
    logStart = wrLog.size();
    for (int i = 0; i < 10; i++) begin
      setIdle();
      st_valid = 1'b1;
      st_addr  = 32'h80 + 32'((i % 4) * 8);
      st_data  = 64'h1000 + 64'(i);
      expWr[i] = {st_addr, st_data};
      refMem[i % 4] = st_data;
      @(negedge clk);
      if (i % 3 == 2) begin
        setIdle();
        @(negedge clk);
      end
    end
    setIdle();
    waited = 0;
    while (empty !== 1'b1 && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    nCompared++; if (empty !== 1'b1) begin nMismatched++; $display("[TB] FAIL wrap_timeout: empty %b after %0d cycles, want 1", empty, waited); end
    nCompared++; if (wrLog.size() - logStart !== 10) begin nMismatched++; $display("[TB] FAIL wrap_write_count: got %0d want 10", wrLog.size() - logStart); end
    if (wrLog.size() - logStart == 10) begin
      for (int i = 0; i < 10; i++) begin
        nCompared++; if (wrLog[logStart + i] !== expWr[i]) begin nMismatched++; $display("[TB] FAIL wrap_order%0d: got %h want %h", i, wrLog[logStart + i], expWr[i]); end
      end
    end
    for (int j = 0; j < 4; j++) begin
      nCompared++; if (dmem[16 + j] !== refMem[j]) begin nMismatched++; $display("[TB] FAIL wrap_mem%0d: got %h want %h", j, dmem[16 + j], refMem[j]); end
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_drain();
    int logStart;
    logStart = wrLog.size();
    for (int i = 0; i < 3; i++) begin
      setIdle();
      st_valid = 1'b1; st_addr = 32'hC0 + 32'(i * 8); st_data = 64'h111 * 64'(i + 1);
      ld_valid = 1'b1; ld_addr = 32'h200;
      @(negedge clk);
    end
    setIdle();
    #1;
    nCompared++; if (count !== 3'd3) begin nMismatched++; $display("[TB] FAIL mid_count: got %0d want 3", count); end
    nCompared++; if (mem_addr !== 32'hC0) begin nMismatched++; $display("[TB] FAIL mid_first_addr: got %h want c0", mem_addr); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    nCompared++; if (mem_wr_en !== 1'b0) begin nMismatched++; $display("[TB] FAIL mid_rst_wr_en: got %b want 0", mem_wr_en); end
    nCompared++; if (count !== 3'd0) begin nMismatched++; $display("[TB] FAIL mid_rst_count: got %0d want 0", count); end
    @(negedge clk);
    rst = 1'b1;
    #1;
    nCompared++; if (empty !== 1'b1) begin nMismatched++; $display("[TB] FAIL mid_post_empty: got %b want 1", empty); end
    nCompared++; if (mem_wr_en !== 1'b0) begin nMismatched++; $display("[TB] FAIL mid_post_wr_en: got %b want 0", mem_wr_en); end
    repeat (3) @(negedge clk);
    nCompared++; if (wrLog.size() - logStart !== 1) begin nMismatched++; $display("[TB] FAIL mid_writes: got %0d want 1", wrLog.size() - logStart); end
    nCompared++; if (dmem[24] !== 64'h111) begin nMismatched++; $display("[TB] FAIL mid_mem0: got %h want 111", dmem[24]); end
    nCompared++; if (dmem[25] !== 64'd0) begin nMismatched++; $display("[TB] FAIL mid_mem1: got %h want 0", dmem[25]); end
    nCompared++; if (dmem[26] !== 64'd0) begin nMismatched++; $display("[TB] FAIL mid_mem2: got %h want 0", dmem[26]); end
  endtask

  // Main sequence: power-up reset, then each scenario in turn.
  initial begin
    nCompared   = 0;
    nMismatched = 0;
    for (int i = 0; i < 256; i++) dmem[i] = '0;
    dmem[4] = 64'hDEAD_0004;
    dmem[5] = 64'hBEEF_0005;
    rst   = 1'b0;
    drain = 1'b0;
    setIdle();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    test_reset();
    test_basic_drain();
    test_forward();
    test_full_stall();
    test_back_to_back();
    test_reset_mid_drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- FIFO write buffer between the MEM stage and the data memory write port.
- Stores retire into the buffer in one cycle and drain to memory in order, one per cycle, whenever the memory port is not needed by a load.
- Loads check the buffer combinationally and forward the youngest matching store's data.

Parameters:
DEPTH, 4, number of buffered stores; power of two, at least 2
ADDR_W, 32, byte address width
DATA_W, 64, store/load word width

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset; synchronous, active-low (0 = reset)
st_valid  in  1  MEM-stage store present (mem_write)
st_addr  in  ADDR_W  store byte address (ALU result)
st_data  in  DATA_W  store data
st_ready  out  1  buffer can accept a store this cycle
ld_valid  in  1  MEM-stage load present (mem_read)
ld_addr  in  ADDR_W  load byte address
ld_stall  out  1  load must hold in MEM this cycle
ld_data  out  DATA_W  load result (forwarded or memory)
mem_rd_data  in  DATA_W  data memory combinational read data
mem_addr  out  ADDR_W  data memory address
mem_wr_data  out  DATA_W  data memory write data
mem_wr_en  out  1  data memory write enable
mem_rd_en  out  1  data memory read enable
drain  in  1  fence: stop accepting stores until empty
empty  out  1  no buffered stores
count  out  $clog2(DEPTH)+1  occupancy

Behaviour:
- Storage is a circular array of entries {addr, data}.
- head/tail pointers are $clog2(DEPTH)+1 bits. empty = (head==tail). full = index bits equal and MSBs differ.
- Reset (rst==0 at a clk edge):
  - head=tail=0; all buffered stores are discarded, including mid-drain.
  - While rst==0: st_ready=0, ld_stall=0, mem_wr_en=0, mem_rd_en=0, ld_data=0, mem_addr=0, mem_wr_data=0, empty=1, count=0.
- Enqueue:
  - st_ready = !full && !drain.
  - When st_valid && st_ready: write the entry at tail; tail+1 at the edge.
  - The entry is eligible to drain from the next cycle (minimum 1-cycle latency to memory).
- Port arbitration, one memory access per cycle:
  - full && ld_valid: drain wins; ld_stall=1.
  - ld_valid otherwise: load wins; mem_rd_en=1, mem_addr=ld_addr, ld_stall=0, no drain.
  - !ld_valid && !empty: drain. mem_wr_en=1, mem_addr/mem_wr_data from the head entry; head+1 at the edge.
- Forwarding:
  - Compare ld_addr[ADDR_W-1:3] against every valid entry.
  - The youngest match (nearest to tail) supplies ld_data; otherwise ld_data = mem_rd_data.
  - Whole-word matching only; unaligned or partial overlap is not supported.
  - An entry enqueued in the same cycle is not forwarded (st_valid and ld_valid are exclusive).
- Simultaneous events:
  - Enqueue and drain in the same cycle: both happen; count unchanged.
  - Enqueue while full: st_ready=0 and the upstream pipeline stalls. There is no bypass.
- Wrap-around: pointer indices wrap modulo DEPTH; the MSB toggles at each wrap.
- drain:
  - Blocks enqueue only. Draining continues per the arbitration rules.
  - The upstream releases drain when empty=1.
- Assertion: st_valid && ld_valid in the same cycle is illegal; the bench flags it.

Decomposition:
- Shared package mem_pkg holds:
  - typedef sb_entry_t {addr, data}
  - SB_DEPTH default
  - WORD_OFFSET_BITS=3 constant
- Sub-module sb_match: combinational youngest-match priority finder. It takes the entry array, head, tail and the load word address, and outputs hit and index.

Test Plan:
- Reset behaviour: rst=0 for 2 cycles after random traffic -> empty=1, count=0, mem_wr_en=0, st_ready=0. With rst=1 and no traffic, st_ready=1 on the first cycle.
- Basic drain: store 0x10←5 with no loads -> count=1 next cycle; mem_wr_en=1 with addr 0x10 / data 5 that cycle; empty=1 after.
- Forwarding, youngest wins: stores 0x20←1 then 0x20←2 while loads hold the port, then load 0x20 -> ld_data=2, mem_rd_en=1, no drain that cycle.
- Full and stall: DEPTH=4 stores with continuous loads -> st_ready=0 at count=4. A load on the next cycle sees ld_stall=1 while head drains, then count=3.
- Wrap-around: 10 stores with interleaved idle cycles -> memory writes observed in program order, no lost or duplicate writes. Final data memory matches a reference model.
- Reset mid-drain: 3 buffered stores, rst=0 during a drain cycle -> no further mem_wr_en, count=0. Only writes drained before reset are present in memory.
